// File: rtl/ram_tdp_arbiter.sv
// Round-robin arbiter sharing a dual-port CS/OE RAM among NREQ requesters.
// Two grants per cycle, address-collision blocking, 2-cycle read return.
module ram_tdp_arbiter #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [NREQ*DWIDTH-1:0]   rdata,
  output logic                     cs_0,
  output logic                     oe_0,
  output logic                     we_0,
  output logic [AWIDTH-1:0]        addr_0,
  output logic [DWIDTH-1:0]        din_0,
  input  logic [DWIDTH-1:0]        dout_0,
  output logic                     cs_1,
  output logic                     oe_1,
  output logic                     we_1,
  output logic [AWIDTH-1:0]        addr_1,
  output logic [DWIDTH-1:0]        din_1,
  input  logic [DWIDTH-1:0]        dout_1,
  output logic [7:0]               conflict_cnt
);

  localparam int PW = $clog2(NREQ);
  typedef logic [PW-1:0] idx_t;

  function automatic idx_t f_rot(input idx_t p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return idx_t'(s);
  endfunction

  idx_t              r_ptr;
  logic [7:0]        r_cnt;
  logic [1:0]        r_cs;
  logic [1:0]        r_oe;
  logic [1:0]        r_we;
  logic [AWIDTH-1:0] r_addr [2];
  logic [DWIDTH-1:0] r_din  [2];
  logic [1:0]        r_t1v;
  logic [1:0]        r_t2v;
  idx_t              r_t1i  [2];
  idx_t              r_t2i  [2];

  logic              w_a_vld;
  logic              w_b_vld;
  idx_t              w_a_idx;
  idx_t              w_b_idx;
  logic              w_conf;
  logic              w_b_gnt;
  idx_t              w_nxt;
  logic [1:0]        w_pv;
  idx_t              w_pi   [2];
  logic [DWIDTH-1:0] w_dout [2];

  always_comb begin
    w_a_vld = 1'b0;
    w_b_vld = 1'b0;
    w_a_idx = '0;
    w_b_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req[f_rot(r_ptr, k)]) begin
        if (!w_a_vld) begin
          w_a_vld = 1'b1;
          w_a_idx = f_rot(r_ptr, k);
        end else if (!w_b_vld) begin
          w_b_vld = 1'b1;
          w_b_idx = f_rot(r_ptr, k);
        end
      end
    end
  end

  // Same-address pairs collide unless both are reads.
  assign w_conf = w_a_vld && w_b_vld
    && (req_addr[w_a_idx*AWIDTH +: AWIDTH]
        == req_addr[w_b_idx*AWIDTH +: AWIDTH])
    && (req_we[w_a_idx] || req_we[w_b_idx]);

  assign w_b_gnt   = w_b_vld && !w_conf;
  assign w_nxt     = f_rot(w_b_gnt ? w_b_idx : w_a_idx, 1);
  assign w_pv      = {w_b_gnt, w_a_vld};
  assign w_pi[0]   = w_a_idx;
  assign w_pi[1]   = w_b_idx;
  assign w_dout[0] = dout_0;
  assign w_dout[1] = dout_1;

  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (w_a_vld) gnt[w_a_idx] = 1'b1;
      if (w_b_gnt) gnt[w_b_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_cs  <= '0;
      r_oe  <= '0;
      r_we  <= '0;
      r_t1v <= '0;
      r_t2v <= '0;
      for (int p = 0; p < 2; p++) begin
        r_addr[p] <= '0;
        r_din[p]  <= '0;
        r_t1i[p]  <= '0;
        r_t2i[p]  <= '0;
      end
    end else begin
      if (w_a_vld) r_ptr <= w_nxt;
      if (w_conf && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
      for (int p = 0; p < 2; p++) begin
        r_cs[p] <= w_pv[p];
        r_we[p] <= w_pv[p] & req_we[w_pi[p]];
        r_oe[p] <= w_pv[p] & ~req_we[w_pi[p]];
        r_addr[p] <= w_pv[p]
          ? req_addr[w_pi[p]*AWIDTH +: AWIDTH] : '0;
        r_din[p] <= (w_pv[p] && req_we[w_pi[p]])
          ? req_wdata[w_pi[p]*DWIDTH +: DWIDTH] : '0;
        r_t1v[p] <= w_pv[p] & ~req_we[w_pi[p]];
        r_t1i[p] <= w_pi[p];
        r_t2i[p] <= r_t1i[p];
      end
      r_t2v <= r_t1v;
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_t2v[p]) begin
        rvalid[r_t2i[p]] = 1'b1;
        rdata[r_t2i[p]*DWIDTH +: DWIDTH] = w_dout[p];
      end
    end
  end

  assign cs_0   = r_cs[0];
  assign oe_0   = r_oe[0];
  assign we_0   = r_we[0];
  assign addr_0 = r_addr[0];
  assign din_0  = r_din[0];
  assign cs_1   = r_cs[1];
  assign oe_1   = r_oe[1];
  assign we_1   = r_we[1];
  assign addr_1 = r_addr[1];
  assign din_1  = r_din[1];
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_ram_tdp_arbiter.sv
// Bench for ram_tdp_arbiter: RAM model, behavioural reference,
// directed scenarios and randomized held-request traffic.
module tb_ram_tdp_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [N*DW-1:0] rdata;
  logic cs_0, oe_0, we_0, cs_1, oe_1, we_1;
  logic [AW-1:0] addr_0, addr_1;
  logic [DW-1:0] din_0, din_1;
  logic [DW-1:0] dout_0 = '0;
  logic [DW-1:0] dout_1 = '0;
  logic [7:0] conflict_cnt;

  always #5 clk = ~clk;

  ram_tdp_arbiter #(.NREQ(N), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0),
    .addr_0(addr_0), .din_0(din_0), .dout_0(dout_0),
    .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1),
    .addr_1(addr_1), .din_1(din_1), .dout_1(dout_1),
    .conflict_cnt(conflict_cnt)
  );

  // synchronous dual-port RAM, read data one cycle after the pins
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (cs_0 && we_0) ram[addr_0] <= din_0;
    if (cs_1 && we_1) ram[addr_1] <= din_1;
    if (cs_0 && oe_0) dout_0 <= ram[addr_0];
    if (cs_1 && oe_1) dout_1 <= ram[addr_1];
  end

  int vec = 0;
  int miss = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] ad(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wd(input int i);
    return req_wdata[i*DW +: DW];
  endfunction

  // reference model state
  logic [DW-1:0] mm [1<<AW];
  logic [N-1:0]  m_gnt = '0;
  logic [N-1:0]  rv1 = '0;
  logic [N-1:0]  rv2 = '0;
  logic [DW-1:0] rd1 [N];
  logic [DW-1:0] rd2 [N];
  logic [14:0]   e_pin [2];
  int mptr = 0;
  int mcnt = 0;

  always @(negedge clk) begin : model
    int lst[$];
    logic [N-1:0] eg;
    logic [N*DW-1:0] er;
    int a, b, w;
    bit bg;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_pins",
          32'({cs_0, oe_0, we_0, cs_1, oe_1, we_1}), 32'h0);
      chk("rst_bus",
          32'({addr_0, addr_1, din_0, din_1}), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_cnt", 32'(conflict_cnt), 32'h0);
      mptr = 0;
      mcnt = 0;
      m_gnt = '0;
      rv1 = '0;
      rv2 = '0;
      e_pin[0] = '0;
      e_pin[1] = '0;
    end else begin
      lst.delete();
      for (int k = 0; k < N; k++)
        if (req[(mptr + k) % N]) lst.push_back((mptr + k) % N);
      eg = '0;
      a = -1;
      b = -1;
      bg = 1'b0;
      if (lst.size() > 0) begin
        a = lst[0];
        eg[a] = 1'b1;
      end
      if (lst.size() > 1) begin
        b = lst[1];
        bg = !(ad(a) == ad(b) && (req_we[a] || req_we[b]));
        if (bg) eg[b] = 1'b1;
      end
      er = '0;
      for (int i = 0; i < N; i++)
        if (rv2[i]) er[i*DW +: DW] = rd2[i];
      chk("gnt", 32'(gnt), 32'(eg));
      chk("port0", 32'({cs_0, oe_0, we_0, addr_0, din_0}),
          32'(e_pin[0]));
      chk("port1", 32'({cs_1, oe_1, we_1, addr_1, din_1}),
          32'(e_pin[1]));
      chk("rvalid", 32'(rvalid), 32'(rv2));
      chk("rdata", 32'(rdata), 32'(er));
      chk("cnt", 32'(conflict_cnt), 32'(mcnt));
      rv2 = rv1;
      rd2 = rd1;
      rv1 = '0;
      for (int p = 0; p < 2; p++) begin
        w = (p == 0) ? a : (bg ? b : -1);
        if (w < 0) begin
          e_pin[p] = '0;
        end else if (req_we[w]) begin
          e_pin[p] = {3'b101, ad(w), wd(w)};
          mm[ad(w)] = wd(w);
        end else begin
          e_pin[p] = {3'b110, ad(w), 8'h00};
          rv1[w] = 1'b1;
          rd1[w] = mm[ad(w)];
        end
      end
      if (b >= 0 && !bg && mcnt < 255) mcnt++;
      if (a >= 0) mptr = ((bg ? b : a) + 1) % N;
      m_gnt = eg;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input bit we,
                        input int a, input int d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = AW'(a);
    req_wdata[i*DW +: DW] = DW'(d);
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) step();
  endtask

  task automatic rstpulse();
    idle(3);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic int initd(input int k);
    return (k == 3) ? 32'hA5 : ((k * 37 + 5) & 32'hFF);
  endfunction

  int rcount [N];

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < (1 << AW); k++) begin
      req = '0;
      setreq(0, 1'b1, k, initd(k));
      step();
    end

    // single read of preloaded 0xA5
    rstpulse();
    setreq(2, 1'b0, 3, 0);
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h4);
    step();
    req = '0;
    @(negedge clk);
    chk("single_pins", 32'({cs_0, oe_0, we_0, addr_0}), 32'h63);
    step();
    @(negedge clk);
    chk("single_rv", 32'(rvalid), 32'h4);
    chk("single_rd", 32'(rdata[2*DW +: DW]), 32'hA5);

    // dual grant: write on port 0, read on port 1
    rstpulse();
    setreq(0, 1'b1, 1, 8'h11);
    setreq(1, 1'b0, 2, 0);
    @(negedge clk);
    chk("dual_gnt", 32'(gnt), 32'h3);
    step();
    req = '0;
    @(negedge clk);
    chk("dual_p0", 32'({cs_0, we_0, addr_0, din_0}), 32'h3111);
    chk("dual_p1", 32'({cs_1, oe_1, we_1, addr_1}), 32'h62);
    step();
    @(negedge clk);
    chk("dual_rv", 32'(rvalid), 32'h2);

    // conflict: write then read of same address
    rstpulse();
    setreq(0, 1'b1, 5, 8'h5A);
    setreq(3, 1'b0, 5, 0);
    @(negedge clk);
    chk("conf_gnt", 32'(gnt), 32'h1);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("conf_cnt", 32'(conflict_cnt), 32'h1);
    chk("conf_gnt2", 32'(gnt), 32'h8);
    step();
    req = '0;
    step();
    @(negedge clk);
    chk("conf_rv", 32'(rvalid), 32'h8);
    chk("conf_rd", 32'(rdata[3*DW +: DW]), 32'h5A);

    // fairness: four readers for eight cycles
    rstpulse();
    for (int i = 0; i < N; i++) begin
      setreq(i, 1'b0, 8 + i, 0);
      rcount[i] = 0;
    end
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (rvalid[i]) rcount[i]++;
      if (c < 8)
        chk("fair_gnt", 32'(gnt), (c % 2 == 1) ? 32'hC : 32'h3);
      step();
      if (c == 7) req = '0;
    end
    for (int i = 0; i < N; i++)
      chk("fair_count", rcount[i], 4);

    // saturation: 300 same-address write conflicts
    rstpulse();
    setreq(0, 1'b1, 7, 8'h70);
    setreq(1, 1'b1, 7, 8'h71);
    repeat (300) step();
    req = '0;
    @(negedge clk);
    chk("sat_cnt", 32'(conflict_cnt), 32'd255);

    // reset while a read is in flight
    rstpulse();
    setreq(2, 1'b0, 3, 0);
    @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'h4);
    step();
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_pins", 32'({cs_0, oe_0, we_0, addr_0}), 32'h0);
    step();
    @(negedge clk);
    chk("mid_rv", 32'(rvalid), 32'h0);
    step();
    rst_n = 1'b1;
    setreq(1, 1'b0, 4, 0);
    @(negedge clk);
    chk("mid_resume", 32'(gnt), 32'h2);
    step();
    req = '0;
    step();
    @(negedge clk);
    chk("mid_rv2", 32'(rvalid), 32'h2);
    chk("mid_rd2", 32'(rdata[1*DW +: DW]), 32'h99);

    // randomized traffic, requests held until granted
    rstpulse();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || m_gnt[i]) begin
          req[i] = ($urandom_range(3) != 0);
          req_we[i] = $urandom_range(1) == 1;
          req_addr[i*AW +: AW] = AW'($urandom_range(3));
          req_wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
